// File: rtl/sa_tile_sched_pkg.sv
// Shared types for the systolic-array tile scheduler: FSM states and the latched tile command.
package sa_pkg;

  localparam int unsigned CNT_MAX_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT,
    DONE
  } sched_state_e;

  typedef struct packed {
    logic [CNT_MAX_W-1:0] num_m;
    logic [CNT_MAX_W-1:0] num_n;
    logic [CNT_MAX_W-1:0] num_k;
  } tile_cmd_t;

endpackage

// File: rtl/sa_tile_sched_if.sv
// Host command channel plus engine start/done handshake and per-tile addressing of the tile scheduler.
interface sa_tile_sched_if #(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned ADDR_W = 8
);
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [CNT_W-1:0]  i_num_m;
  logic [CNT_W-1:0]  i_num_n;
  logic [CNT_W-1:0]  i_num_k;
  logic              i_abort;
  logic              o_eng_start;
  logic              i_eng_done;
  logic [ADDR_W-1:0] o_in_base;
  logic [ADDR_W-1:0] o_w_base;
  logic [ADDR_W-1:0] o_out_base;
  logic              o_acc;
  logic              o_busy;
  logic              o_done;
  logic              o_aborted;

  modport master (
    output i_cmd_valid, i_num_m, i_num_n, i_num_k, i_abort, i_eng_done,
    input  o_cmd_ready, o_eng_start, o_in_base, o_w_base, o_out_base,
           o_acc, o_busy, o_done, o_aborted
  );

  modport slave (
    input  i_cmd_valid, i_num_m, i_num_n, i_num_k, i_abort, i_eng_done,
    output o_cmd_ready, o_eng_start, o_in_base, o_w_base, o_out_base,
           o_acc, o_busy, o_done, o_aborted
  );
endinterface

// File: rtl/sa_tile_cnt.sv
// Nested m/n/k tile counter, k innermost; flags the wrap points and the final tile of a command.
module sa_tile_cnt
  import sa_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  tile_cmd_t        i_cmd,
  input  logic             i_step,
  output logic [CNT_W-1:0] o_k,
  output logic             o_k_last,
  output logic             o_n_last,
  output logic             o_last
);

  tile_cmd_t        r_cmd;
  logic [CNT_W-1:0] r_m;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_k;
  logic             w_m_last;

  always_comb begin
    o_k_last = (r_k == CNT_W'(r_cmd.num_k - CNT_MAX_W'(1)));
    o_n_last = (r_n == CNT_W'(r_cmd.num_n - CNT_MAX_W'(1)));
    w_m_last = (r_m == CNT_W'(r_cmd.num_m - CNT_MAX_W'(1)));
    o_last   = o_k_last && o_n_last && w_m_last;
  end

  assign o_k = r_k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= '0;
      r_m   <= '0;
      r_n   <= '0;
      r_k   <= '0;
    end else if (i_load) begin
      r_cmd <= i_cmd;
      r_m   <= '0;
      r_n   <= '0;
      r_k   <= '0;
    end else if (i_step) begin
      if (!o_k_last) begin
        r_k <= r_k + CNT_W'(1);
      end else begin
        r_k <= '0;
        if (!o_n_last) begin
          r_n <= r_n + CNT_W'(1);
        end else begin
          r_n <= '0;
          r_m <= r_m + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sa_tile_sched.sv
// GEMM tile scheduler: accepts one M x N x K command and issues one engine start per tile,
// k innermost, with base addresses built by stride accumulators instead of multipliers.
module sa_tile_sched
  import sa_pkg::*;
#(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned IN_STRIDE  = 8,
  parameter int unsigned W_STRIDE   = 8,
  parameter int unsigned OUT_STRIDE = 8
) (
  input logic            clk,
  input logic            rst_n,
  sa_tile_sched_if.slave bus
);

  localparam logic [ADDR_W-1:0] IN_S  = ADDR_W'(IN_STRIDE);
  localparam logic [ADDR_W-1:0] W_S   = ADDR_W'(W_STRIDE);
  localparam logic [ADDR_W-1:0] OUT_S = ADDR_W'(OUT_STRIDE);

  sched_state_e      r_state, w_next;
  tile_cmd_t         w_cmd;
  logic              w_accept, w_zero, w_step, w_end_abort;
  logic              w_k_last, w_n_last, w_last;
  logic [CNT_W-1:0]  w_k;
  logic              r_aborted;
  logic [ADDR_W-1:0] r_in, r_in_row, r_w, r_w_col, r_w_kstep, r_out;

  always_comb begin
    w_cmd.num_m = CNT_MAX_W'(bus.i_num_m);
    w_cmd.num_n = CNT_MAX_W'(bus.i_num_n);
    w_cmd.num_k = CNT_MAX_W'(bus.i_num_k);
    w_zero      = (bus.i_num_m == '0) || (bus.i_num_n == '0) || (bus.i_num_k == '0);
  end

  sa_tile_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept),
    .i_cmd    (w_cmd),
    .i_step   (w_step),
    .o_k      (w_k),
    .o_k_last (w_k_last),
    .o_n_last (w_n_last),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // A zero-count command passes through NEXT with the abort flag preset, so it ends
  // with the same two-cycle accept-to-done spacing as a normal final tile.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_end_abort = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_cmd_valid) begin
          w_accept = 1'b1;
          w_next   = w_zero ? NEXT : ISSUE;
        end
      end
      ISSUE: w_next = WAIT;
      WAIT:  if (bus.i_eng_done) w_next = NEXT;
      NEXT: begin
        if (bus.i_abort || r_aborted) begin
          w_end_abort = 1'b1;
          w_next      = DONE;
        end else if (w_last) begin
          w_next = DONE;
        end else begin
          w_step = 1'b1;
          w_next = ISSUE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // in_row tracks m*num_k*IN_S, w_col tracks n*W_S; k wrap rewinds, n wrap carries forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aborted <= 1'b0;
      r_in      <= '0;
      r_in_row  <= '0;
      r_w       <= '0;
      r_w_col   <= '0;
      r_w_kstep <= '0;
      r_out     <= '0;
    end else if (w_accept) begin
      r_aborted <= w_zero;
      r_in      <= '0;
      r_in_row  <= '0;
      r_w       <= '0;
      r_w_col   <= '0;
      r_w_kstep <= ADDR_W'(bus.i_num_n) * W_S;
      r_out     <= '0;
    end else begin
      if (w_end_abort) r_aborted <= 1'b1;
      if (w_step) begin
        if (!w_k_last) begin
          r_in <= r_in + IN_S;
          r_w  <= r_w + r_w_kstep;
        end else if (!w_n_last) begin
          r_in    <= r_in_row;
          r_w     <= r_w_col + W_S;
          r_w_col <= r_w_col + W_S;
          r_out   <= r_out + OUT_S;
        end else begin
          r_in     <= r_in + IN_S;
          r_in_row <= r_in + IN_S;
          r_w      <= '0;
          r_w_col  <= '0;
          r_out    <= r_out + OUT_S;
        end
      end
    end
  end

  assign bus.o_cmd_ready = (r_state == IDLE);
  assign bus.o_busy      = (r_state != IDLE);
  assign bus.o_eng_start = (r_state == ISSUE);
  assign bus.o_done      = (r_state == DONE);
  assign bus.o_aborted   = (r_state == DONE) && r_aborted;
  assign bus.o_acc       = (w_k != '0);
  assign bus.o_in_base   = r_in;
  assign bus.o_w_base    = r_w;
  assign bus.o_out_base  = r_out;

endmodule

// File: tb/tb_sa_tile_sched.sv
// Directed bench for sa_tile_sched: per-tile vector tables plus hand-written abort, zero-count,
// spurious-handshake and mid-command reset sequences; a second instance uses 4-bit addresses.
module tb_sa_tile_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_tile_sched_if #(.CNT_W(4), .ADDR_W(8)) bus ();
  sa_tile_sched_if #(.CNT_W(4), .ADDR_W(4)) bus4 ();

  sa_tile_sched #(.CNT_W(4), .ADDR_W(8), .IN_STRIDE(8), .W_STRIDE(8), .OUT_STRIDE(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  sa_tile_sched #(.CNT_W(4), .ADDR_W(4), .IN_STRIDE(8), .W_STRIDE(8), .OUT_STRIDE(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4));

  logic       sel, cmd_valid, eng_done, abort;
  logic [3:0] nm, nn, nk;

  assign bus.i_cmd_valid  = cmd_valid & ~sel;
  assign bus.i_eng_done   = eng_done & ~sel;
  assign bus.i_abort      = abort & ~sel;
  assign bus.i_num_m      = nm;
  assign bus.i_num_n      = nn;
  assign bus.i_num_k      = nk;
  assign bus4.i_cmd_valid = cmd_valid & sel;
  assign bus4.i_eng_done  = eng_done & sel;
  assign bus4.i_abort     = abort & sel;
  assign bus4.i_num_m     = nm;
  assign bus4.i_num_n     = nn;
  assign bus4.i_num_k     = nk;

  logic       s_ready, s_start, s_acc, s_busy, s_done, s_aborted;
  logic [7:0] s_in, s_w, s_out;

  always_comb begin
    s_ready   = sel ? bus4.o_cmd_ready : bus.o_cmd_ready;
    s_start   = sel ? bus4.o_eng_start : bus.o_eng_start;
    s_acc     = sel ? bus4.o_acc       : bus.o_acc;
    s_busy    = sel ? bus4.o_busy      : bus.o_busy;
    s_done    = sel ? bus4.o_done      : bus.o_done;
    s_aborted = sel ? bus4.o_aborted   : bus.o_aborted;
    s_in      = sel ? {4'h0, bus4.o_in_base}  : bus.o_in_base;
    s_w       = sel ? {4'h0, bus4.o_w_base}   : bus.o_w_base;
    s_out     = sel ? {4'h0, bus4.o_out_base} : bus.o_out_base;
  end

  typedef struct {
    int unsigned lat;
    logic [7:0]  in_b;
    logic [7:0]  w_b;
    logic [7:0]  out_b;
    logic        acc;
  } tile_vec_t;

  tile_vec_t tv[25];
  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  function automatic tile_vec_t tvr(input int unsigned l, input logic [7:0] a, input logic [7:0] b,
                                    input logic [7:0] c, input logic d);
    tile_vec_t t;
    t.lat = l; t.in_b = a; t.w_b = b; t.out_b = c; t.acc = d;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic accept(input logic [3:0] m, input logic [3:0] n, input logic [3:0] k);
    nm = m; nn = n; nk = k;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output int unsigned n);
    n = 0;
    while (s_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", 32'(s_start), 1);
  endtask

  task automatic pulse_done();
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
  endtask

  task automatic run_tiles(input int first, input int cnt);
    int unsigned n;
    for (int i = first; i < first + cnt; i++) begin
      wait_start(n);
      chk($sformatf("start_lat[%0d]", i), n, (i == first) ? 0 : 1);
      chk($sformatf("in_base[%0d]", i),  32'(s_in),  32'(tv[i].in_b));
      chk($sformatf("w_base[%0d]", i),   32'(s_w),   32'(tv[i].w_b));
      chk($sformatf("out_base[%0d]", i), 32'(s_out), 32'(tv[i].out_b));
      chk($sformatf("acc[%0d]", i),      32'(s_acc), 32'(tv[i].acc));
      @(negedge clk);
      chk($sformatf("start_width[%0d]", i), 32'(s_start), 0);
      repeat (tv[i].lat) @(negedge clk);
      pulse_done();
    end
  endtask

  task automatic end_check(input logic exp_ab);
    chk("done_early", 32'(s_done), 0);
    @(negedge clk);
    chk("done", 32'(s_done), 1);
    chk("aborted", 32'(s_aborted), 32'(exp_ab));
    chk("start_after_end", 32'(s_start), 0);
    @(negedge clk);
    chk("ready_after_done", 32'(s_ready), 1);
    chk("done_width", 32'(s_done), 0);
  endtask

  initial begin
    int unsigned n;
    sel = 1'b0; cmd_valid = 1'b0; eng_done = 1'b0; abort = 1'b0;
    nm = '0; nn = '0; nk = '0;

    tv[0] = tvr(0, 8'd0, 8'd0, 8'd0, 1'b0);
    tv[1] = tvr(0, 8'd0,  8'd0,  8'd0, 1'b0); tv[2] = tvr(1, 8'd8,  8'd16, 8'd0, 1'b1);
    tv[3] = tvr(2, 8'd16, 8'd32, 8'd0, 1'b1); tv[4] = tvr(0, 8'd0,  8'd8,  8'd8, 1'b0);
    tv[5] = tvr(3, 8'd8,  8'd24, 8'd8, 1'b1); tv[6] = tvr(1, 8'd16, 8'd40, 8'd8, 1'b1);
    tv[7] = tvr(1, 8'd0, 8'd0, 8'd0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      tv[9 + 8*r]  = tvr(0, 8'd0, 8'd0, 8'd0, 1'b0); tv[10 + 8*r] = tvr(1, 8'd8, 8'd8, 8'd0, 1'b1);
      tv[11 + 8*r] = tvr(0, 8'd0, 8'd0, 8'd0, 1'b1); tv[12 + 8*r] = tvr(2, 8'd8, 8'd8, 8'd0, 1'b1);
      tv[13 + 8*r] = tvr(0, 8'd0, 8'd0, 8'd8, 1'b0); tv[14 + 8*r] = tvr(1, 8'd8, 8'd8, 8'd8, 1'b1);
      tv[15 + 8*r] = tvr(0, 8'd0, 8'd0, 8'd8, 1'b1); tv[16 + 8*r] = tvr(0, 8'd8, 8'd8, 8'd8, 1'b1);
    end

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(s_ready), 1);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_start", 32'(s_start), 0);
    chk("rst_done", 32'(s_done), 0);
    chk("rst_aborted", 32'(s_aborted), 0);
    chk("rst_bases", {8'h0, s_in, s_w, s_out}, 0);
    chk("rst_acc", 32'(s_acc), 0);

    accept(4'd1, 4'd1, 4'd1);
    run_tiles(0, 1);
    end_check(1'b0);

    accept(4'd1, 4'd2, 4'd3);
    run_tiles(1, 6);
    end_check(1'b0);

    accept(4'd1, 4'd1, 4'd0);
    chk("zero_start", 32'(s_start), 0);
    chk("zero_busy", 32'(s_busy), 1);
    chk("zero_done_early", 32'(s_done), 0);
    @(negedge clk);
    chk("zero_done", 32'(s_done), 1);
    chk("zero_aborted", 32'(s_aborted), 1);
    chk("zero_no_start", 32'(s_start), 0);
    @(negedge clk);
    chk("zero_ready", 32'(s_ready), 1);

    accept(4'd2, 4'd2, 4'd2);
    run_tiles(7, 1);
    wait_start(n);
    chk("abort_t2_lat", n, 1);
    chk("abort_t2_in", 32'(s_in), 8);
    chk("abort_t2_w", 32'(s_w), 16);
    chk("abort_t2_out", 32'(s_out), 0);
    chk("abort_t2_acc", 32'(s_acc), 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_inflight_busy", 32'(s_busy), 1);
    pulse_done();
    end_check(1'b1);
    chk("abort_no_restart", 32'(s_start), 0);
    repeat (2) @(negedge clk);
    chk("abort_idle_busy", 32'(s_busy), 0);
    chk("abort_idle_done", 32'(s_done), 0);
    abort = 1'b0;

    pulse_done();
    chk("spur_idle_ready", 32'(s_ready), 1);
    chk("spur_idle_busy", 32'(s_busy), 0);
    chk("spur_idle_start", 32'(s_start), 0);
    nm = 4'd1; nn = 4'd1; nk = 4'd2;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("spur_t1_start", 32'(s_start), 1);
    chk("spur_t1_in", 32'(s_in), 0);
    nm = 4'd3; nn = 4'd3; nk = 4'd3;
    pulse_done();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("spur_hold_start[%0d]", c), 32'(s_start), 0);
      chk($sformatf("spur_hold_busy[%0d]", c), 32'(s_busy), 1);
      chk($sformatf("spur_hold_done[%0d]", c), 32'(s_done), 0);
      @(negedge clk);
    end
    pulse_done();
    wait_start(n);
    chk("spur_t2_lat", n, 1);
    chk("spur_t2_in", 32'(s_in), 8);
    chk("spur_t2_w", 32'(s_w), 8);
    chk("spur_t2_out", 32'(s_out), 0);
    chk("spur_t2_acc", 32'(s_acc), 1);
    @(negedge clk);
    pulse_done();
    cmd_valid = 1'b0;
    end_check(1'b0);

    sel = 1'b1;
    accept(4'd4, 4'd1, 4'd4);
    run_tiles(9, 16);
    end_check(1'b0);
    sel = 1'b0;

    accept(4'd1, 4'd2, 4'd3);
    run_tiles(1, 1);
    wait_start(n);
    chk("rstmid_in_before", 32'(s_in), 8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(s_busy), 0);
    chk("rstmid_ready", 32'(s_ready), 1);
    chk("rstmid_bases", {8'h0, s_in, s_w, s_out}, 0);
    chk("rstmid_acc", 32'(s_acc), 0);
    @(negedge clk);
    pulse_done();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid_no_done[%0d]", c), 32'(s_done), 0);
      chk($sformatf("rstmid_idle[%0d]", c), 32'(s_ready), 1);
    end
    accept(4'd1, 4'd2, 4'd3);
    run_tiles(1, 6);
    end_check(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sa_tile_sched.md
Name: sa_tile_sched

Overview:
Tile scheduler sitting above the systolic matmul engine. Accepts one GEMM command (M×N×K tile counts), then sequences the engine tile-by-tile: one start pulse per (m,n,k) tile, with memory base addresses and a psum-accumulate flag, waiting for engine done between tiles. Signals command completion to the host. Looping is k innermost, then n, then m.

Parameters:
CNT_W, 4, width of each tile-count field and loop counter
ADDR_W, 8, width of every base-address output; address arithmetic is modulo 2^ADDR_W
IN_STRIDE, 8, input-memory rows per activation tile
W_STRIDE, 8, weight-memory rows per weight tile
OUT_STRIDE, 8, output-memory rows per output tile

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command offered
o_cmd_ready  out  1  scheduler idle, can accept command
i_num_m  in  CNT_W  output tile rows (M tiles)
i_num_n  in  CNT_W  output tile cols (N tiles)
i_num_k  in  CNT_W  reduction tiles (K tiles)
i_abort  in  1  level; stop at next tile boundary
o_eng_start  out  1  one-cycle start pulse to engine
i_eng_done  in  1  one-cycle done pulse from engine
o_in_base  out  ADDR_W  input-memory base address of current tile
o_w_base  out  ADDR_W  weight-memory base address of current tile
o_out_base  out  ADDR_W  output-memory base address of current tile
o_acc  out  1  1 = accumulate onto existing psum (drives load_psum)
o_busy  out  1  command in progress
o_done  out  1  one-cycle completion pulse
o_aborted  out  1  qualifies o_done; 1 = command ended by abort or zero count

Behaviour:
- Reset: state IDLE; all counters, bases, o_eng_start, o_acc, o_done, o_aborted, o_busy = 0; o_cmd_ready = 1.
- States: IDLE, ISSUE, WAIT, NEXT, DONE. o_cmd_ready = (state==IDLE); o_busy = !IDLE.
- IDLE: on i_cmd_valid&&o_cmd_ready, latch i_num_m/n/k, clear counters m=n=k=0. If any count is 0 -> DONE with aborted flag set; else -> ISSUE. i_cmd_valid is ignored when not IDLE.
- ISSUE (1 cycle): o_eng_start=1; -> WAIT.
- WAIT: hold; on i_eng_done -> NEXT. i_eng_done outside WAIT is ignored.
- NEXT (1 cycle): if i_abort -> DONE with aborted. Else if last tile (m,n,k all at count-1) -> DONE. Else advance: k+1; on k wrap k=0,n+1; on n wrap n=0,m+1; -> ISSUE.
- DONE (1 cycle): o_done=1, o_aborted=latched flag; -> IDLE. Flag cleared on next accept.
- Address rules (registered, valid from the ISSUE cycle, stable until the next NEXT):
  o_in_base = (m*num_k + k)*IN_STRIDE; o_w_base = (k*num_n + n)*W_STRIDE; o_out_base = (m*num_n + n)*OUT_STRIDE; all truncated to ADDR_W (wrap, no error).
  o_acc = (k != 0).
- Timing: accept at cycle T -> start at T+1. Engine done at cycle D -> NEXT D+1 -> next start D+2, or o_done D+2 and o_cmd_ready at D+3. Per-tile overhead 2 cycles beyond engine latency.
- Abort sampled only in NEXT; an in-flight engine tile always completes. Abort during IDLE has no effect.
- Reset asserted mid-command: immediate return to reset values; no o_done.

Decomposition:
- sa_pkg: sched_state_e enum (IDLE/ISSUE/WAIT/NEXT/DONE); tile-command struct {num_m,num_n,num_k}.
- Sub-module sa_tile_cnt: nested 3-level wrap counter (k inner) with last-tile flag. Base addresses are computed by incremental stride accumulators, no multipliers.

Test Plan:
- Reset then M=N=K=1: start 1 cycle after accept; bases 0/0/0, o_acc=0; engine done at D -> o_done=1, o_aborted=0 at D+2.
- M=1,N=2,K=3 (strides 8): 6 starts; (n,k) sequence (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); in_base 0,8,16,0,8,16; w_base 0,16,32,8,24,40; out_base 0,0,0,8,8,8; o_acc 0,1,1,0,1,1.
- Command with num_k=0: no o_eng_start; o_done & o_aborted at cycle T+2; ready at T+3.
- i_abort raised during WAIT of tile 2 of M=2,N=2,K=2: tile completes; no further start; o_done & o_aborted 2 cycles after that done.
- i_cmd_valid held high while busy plus spurious i_eng_done in ISSUE/IDLE: no second command accepted, no state change; ADDR_W=4 with M=4,K=4: in_base wraps modulo 16.
- rst_n asserted during WAIT: outputs return to reset values immediately; o_done never pulses; new command afterwards runs normally.
